// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the unary (thermometer) frame generator.
package popcount_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam int DEF_N = 4;

  // Bits needed to hold a count in 0..n
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcount_tx_beat_ctr.sv
// Beat index within a unary frame: cleared on load, stepped on advance, saturates at N-1.
module popcount_tx_beat_ctr #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          advance,
  output logic [CW-1:0] idx,
  output logic          last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              idx <= '0;
    else if (load)           idx <= '0;
    else if (advance && !last) idx <= idx + CW'(1);
  end

endmodule

// File: rtl/popcount_unary_tx.sv
// Count-to-unary frame transmitter: one count in, N thermometer bits out (ones first).
// Optional err_o overflow pulse is built only when POPCOUNT_TX_ERR_EN is defined.
module popcount_unary_tx
  import popcount_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cnt_valid_i,
  output logic          cnt_ready_o,
  input  logic [CW-1:0] cnt_i,
  output logic          bit_valid_o,
  input  logic          bit_ready_i,
  output logic          bit_o,
`ifdef POPCOUNT_TX_ERR_EN
  output logic          err_o,
`endif
  output logic          bit_last_o
);

  localparam logic [CW-1:0] N_CW = CW'(N);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] idx;
  logic          last;
  logic          accept;
  logic          over;
  logic          advance;

  assign over    = (cnt_i > N_CW);
  assign accept  = cnt_valid_i && cnt_ready_o;
  assign advance = (state == SEND) && bit_ready_i && !last;

  // Outputs come from state and registers only; cnt_i never reaches bit_*
  assign bit_valid_o = (state == SEND);
  assign bit_o       = (state == SEND) && (idx < cnt_q);
  assign bit_last_o  = (state == SEND) && last;
  assign cnt_ready_o = (state == IDLE) || ((state == SEND) && bit_ready_i && last);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (bit_ready_i && last) state_nxt = accept ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) cnt_q <= over ? N_CW : cnt_i;
    end
  end

`ifdef POPCOUNT_TX_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_o <= 1'b0;
    else        err_o <= accept && over;
  end
`endif

  popcount_tx_beat_ctr #(.N(N), .CW(CW)) u_beat_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .advance (advance),
    .idx     (idx),
    .last    (last)
  );

endmodule
